// File: rtl/board_shuffler_pkg.sv
// Shared types and helpers for the card-board shuffler: FSM state encoding
// and the power-of-two draw mask used by the Fisher-Yates index draw.
package board_shuffler_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      FILL = 3'd1,
      DRAW = 3'd2,
      SWAP = 3'd3,
      DONE = 3'd4
   } state_t;

   // Smallest 2^k-1 that is >= i, so masked LFSR bits cover 0..i with minimal rejection.
   function automatic int unsigned mask_for(input int unsigned i);
      int unsigned m;
      m = 1;
      for (int k = 0; k < 31; k++) begin
         if (m < i) m = (m << 1) | 1;
      end
      return m;
   endfunction

endpackage

// File: rtl/board_shuffler_if.sv
// Control and read-port bundle between the game FSM / VGA renderer and the shuffler.
interface board_shuffler_if #(
   parameter int ADDR_W = 4,
   parameter int SYM_W  = 3
);
   logic              start;
   logic [ADDR_W-1:0] rd_addr;
   logic [SYM_W-1:0]  rd_data;
   logic              busy;
   logic              rand_ready;
   logic              done;

   modport master (output start, rd_addr, input rd_data, busy, rand_ready, done);
   modport slave  (input start, rd_addr, output rd_data, busy, rand_ready, done);
endinterface

// File: rtl/board_shuffler_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1; a nonzero seed
// keeps it on the maximal-length cycle so it never reaches zero.
module lfsr16 #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] q
);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) q <= SEED;
      else     q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
   end

endmodule

// File: rtl/board_shuffler.sv
// Fills a SLOTS-entry board with symbol pairs, then Fisher-Yates shuffles it
// using a free-running LFSR; the board is exposed through a combinational read port.
module board_shuffler
   import board_shuffler_pkg::*;
#(
   parameter int          SLOTS   = 16,
   parameter int          ADDR_W  = $clog2(SLOTS),
   parameter int          SYM_W   = $clog2(SLOTS / 2),
   parameter logic [15:0] SEED    = 16'hACE1,
   parameter int          MAX_TRY = 8
) (
   input logic             clk,
   input logic             rst,
   board_shuffler_if.slave bus
);

   localparam int                TRY_W    = (MAX_TRY > 1) ? $clog2(MAX_TRY) : 1;
   localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(SLOTS - 1);
   localparam logic [TRY_W-1:0]  TRY_LAST = TRY_W'(MAX_TRY - 1);

   state_t            state, state_nx;
   logic [ADDR_W-1:0] idx, i, j, cand;
   logic [TRY_W-1:0]  tries;
   logic [SYM_W-1:0]  board [SLOTS];
   logic [15:0]       lfsr_q;
   logic              lfsr_unused;
   logic              take, give_up;

   lfsr16 #(.SEED(SEED)) u_lfsr (
      .clk (clk),
      .rst (rst),
      .q   (lfsr_q)
   );

   // Only the low ADDR_W bits feed the draw; the rest of the LFSR just provides the long period.
   assign lfsr_unused = ^lfsr_q[15:ADDR_W];
   assign cand        = lfsr_q[ADDR_W-1:0] & ADDR_W'(mask_for(32'(i)));
   assign take        = (cand <= i);
   assign give_up     = (tries == TRY_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // NOTE: the default assignment up front keeps every path driven, so no latch is inferred.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE, DONE: if (bus.start) state_nx = FILL;
         FILL:       if (idx == LAST) state_nx = DRAW;
         DRAW:       if (take || give_up) state_nx = SWAP;
         SWAP:       state_nx = (i == ADDR_W'(1)) ? DONE : DRAW;
         default:    state_nx = IDLE;
      endcase
   end

   // Outputs decode state only, so start never has a combinational path to them.
   always_comb begin
      bus.busy       = 1'b0;
      bus.rand_ready = 1'b0;
      bus.done       = 1'b0;
      unique case (state)
         FILL, DRAW: bus.busy = 1'b1;
         SWAP: begin
            bus.busy       = 1'b1;
            bus.rand_ready = 1'b1;
         end
         DONE:    bus.done = 1'b1;
         default: ;
      endcase
   end

   assign bus.rd_data = board[bus.rd_addr];

   // NOTE: the board is a flop array, not RAM, so it can take two writes per cycle and be cleared by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx   <= '0;
         i     <= '0;
         j     <= '0;
         tries <= '0;
         for (int k = 0; k < SLOTS; k++) board[k] <= '0;
      end else begin
         unique case (state)
            IDLE, DONE: if (bus.start) idx <= '0;
            FILL: begin
               board[idx] <= SYM_W'(idx >> 1);
               idx        <= idx + 1'b1;
               if (idx == LAST) begin
                  i     <= LAST;
                  tries <= '0;
               end
            end
            DRAW: begin
               if (take)         j <= cand;
               // cand > i here, so cand-i-1 lands in 0..i and the fallback is always a legal index.
               else if (give_up) j <= cand - i - ADDR_W'(1);
               else              tries <= tries + 1'b1;
            end
            SWAP: begin
               board[i] <= board[j];
               board[j] <= board[i];
               tries    <= '0;
               if (i != ADDR_W'(1)) i <= i - 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
